mage_div_arbiter: RTL and testbench

MAGE_DIV_ARBITER -- requirements
Module: mage_div_arbiter

---
 rtl/mage_div_arbiter.sv | 213 +++++++++++++++++++++
 tb/tb_mage_div_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mage_div_arbiter.sv
// mage_div_arbiter
// ----------------
// Round-robin front end for a single shared iterative divider. One of N_REQ
// requesters is granted per operation. At grant time its operands are latched
// and the divisor is normalised (shifted left so its leading significant bit
// sits at the top), then a start pulse goes to the divider. The design waits
// for the divider result, holds it tagged with the requester index until it
// is consumed, and only then returns to IDLE to arbitrate again. Exactly one
// operation is in flight at a time.
//
// Ports
//   Clk_CI, Rst_RBI        clock, asynchronous active-low reset
//   Req_SI                 per-requester request valid
//   ReqOpA_DI / ReqOpB_DI  per-requester dividend / divisor, packed C_WIDTH each
//   ReqOpCode_DI           per-requester opcode (0 udiv, 1 div, 2 urem, 3 rem)
//   Gnt_SO                 one-hot grant, combinational in IDLE only
//   DivOpA_DO, DivOpB_DO   divider operands (B pre-shifted)
//   DivOpBShift_DO         divisor normalisation shift (iteration count - 1)
//   DivOpBIsZero_SO        divisor is zero
//   DivOpBSign_SO          divisor sign, 0 for unsigned opcodes
//   DivOpCode_DO           opcode forwarded to the divider
//   DivInVld_SO            one-cycle start pulse to the divider
//   DivOutVld_SI/DivRes_DI divider result valid / value
//   DivOutRdy_SO           result acknowledge to the divider
//   ResVld_SO, ResId_DO, Res_DO  held result, requester index, value
//   ResRdy_SI              result consumer ready

module mage_div_arbiter #(
  parameter int N_REQ       = 4,
  parameter int C_WIDTH     = 32,
  parameter int C_LOG_WIDTH = 6
) (
  input  logic                       Clk_CI,
  input  logic                       Rst_RBI,
  input  logic [N_REQ-1:0]           Req_SI,
  input  logic [N_REQ*C_WIDTH-1:0]   ReqOpA_DI,
  input  logic [N_REQ*C_WIDTH-1:0]   ReqOpB_DI,
  input  logic [N_REQ*2-1:0]         ReqOpCode_DI,
  output logic [N_REQ-1:0]           Gnt_SO,
  output logic [C_WIDTH-1:0]         DivOpA_DO,
  output logic [C_WIDTH-1:0]         DivOpB_DO,
  output logic [C_LOG_WIDTH-1:0]     DivOpBShift_DO,
  output logic                       DivOpBIsZero_SO,
  output logic                       DivOpBSign_SO,
  output logic [1:0]                 DivOpCode_DO,
  output logic                       DivInVld_SO,
  input  logic                       DivOutVld_SI,
  input  logic [C_WIDTH-1:0]         DivRes_DI,
  output logic                       DivOutRdy_SO,
  output logic                       ResVld_SO,
  output logic [$clog2(N_REQ)-1:0]   ResId_DO,
  output logic [C_WIDTH-1:0]         Res_DO,
  input  logic                       ResRdy_SI
);

  localparam int IDX_W = $clog2(N_REQ);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]       id_q, id_d;
  logic [C_WIDTH-1:0]     opa_q, opa_d;
  logic [C_WIDTH-1:0]     opb_q, opb_d;
  logic [C_LOG_WIDTH-1:0] shift_q, shift_d;
  logic                   bzero_q, bzero_d;
  logic                   bsign_q, bsign_d;
  logic [1:0]             opcode_q, opcode_d;
  logic [C_WIDTH-1:0]     res_q, res_d;

  logic                   any_req;
  logic [IDX_W-1:0]       gnt_idx;
  logic [C_WIDTH-1:0]     sel_a;
  logic [C_WIDTH-1:0]     sel_b;
  logic [1:0]             sel_op;
  logic [C_LOG_WIDTH-1:0] sel_shift;

  // Round-robin search: scan from rr_ptr_q upwards with wrap, first hit wins.
  always_comb begin : arb
    int               idx;
    logic [IDX_W-1:0] cand;
    any_req = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    cand    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx  = (int'(rr_ptr_q) + k) % N_REQ;
      cand = IDX_W'(idx);
      if (!any_req && Req_SI[cand]) begin
        any_req = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  assign sel_a  = ReqOpA_DI[int'(gnt_idx)*C_WIDTH +: C_WIDTH];
  assign sel_b  = ReqOpB_DI[int'(gnt_idx)*C_WIDTH +: C_WIDTH];
  assign sel_op = ReqOpCode_DI[int'(gnt_idx)*2 +: 2];

  // Divisor normalisation. Signed opcodes (OpCode[0]=1) count redundant sign
  // bits below the MSB; unsigned opcodes count leading zeros. Zero divisor
  // is forced to shift 0 so the divider sees a defined iteration count.
  always_comb begin : norm
    logic done;
    int   cnt;
    done = 1'b0;
    cnt  = 0;
    if (sel_op[0]) begin
      for (int i = C_WIDTH-2; i >= 0; i--) begin
        if (!done && (sel_b[i] == sel_b[C_WIDTH-1])) cnt = cnt + 1;
        else done = 1'b1;
      end
    end else begin
      for (int i = C_WIDTH-1; i >= 0; i--) begin
        if (!done && !sel_b[i]) cnt = cnt + 1;
        else done = 1'b1;
      end
    end
    if (sel_b == '0) cnt = 0;
    sel_shift = C_LOG_WIDTH'(cnt);
  end

  // Next-state and register-load logic for the whole FSM datapath.
  always_comb begin : next
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    id_d     = id_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    shift_d  = shift_q;
    bzero_d  = bzero_q;
    bsign_d  = bsign_q;
    opcode_d = opcode_q;
    res_d    = res_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          id_d     = gnt_idx;
          opa_d    = sel_a;
          opb_d    = sel_b << sel_shift;
          shift_d  = sel_shift;
          bzero_d  = (sel_b == '0);
          bsign_d  = sel_op[0] & sel_b[C_WIDTH-1];
          opcode_d = sel_op;
          rr_ptr_d = (int'(gnt_idx) == N_REQ-1) ? '0 : gnt_idx + 1'b1;
          state_d  = ISSUE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (DivOutVld_SI) begin
          res_d   = DivRes_DI;
          state_d = RESP;
        end
      end
      RESP: begin
        if (ResRdy_SI) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      id_q     <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      shift_q  <= '0;
      bzero_q  <= 1'b0;
      bsign_q  <= 1'b0;
      opcode_q <= 2'd0;
      res_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      id_q     <= id_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      shift_q  <= shift_d;
      bzero_q  <= bzero_d;
      bsign_q  <= bsign_d;
      opcode_q <= opcode_d;
      res_q    <= res_d;
    end
  end

  // Grant is combinational in IDLE; gated by reset so it stays low while
  // Rst_RBI is asserted even if requests are already pending.
  always_comb begin : grant
    Gnt_SO = '0;
    if (Rst_RBI && (state_q == IDLE) && any_req) Gnt_SO[gnt_idx] = 1'b1;
  end

  assign DivOpA_DO       = opa_q;
  assign DivOpB_DO       = opb_q;
  assign DivOpBShift_DO  = shift_q;
  assign DivOpBIsZero_SO = bzero_q;
  assign DivOpBSign_SO   = bsign_q;
  assign DivOpCode_DO    = opcode_q;
  assign DivInVld_SO     = (state_q == ISSUE);
  assign DivOutRdy_SO    = (state_q == WAIT) && DivOutVld_SI;
  assign ResVld_SO       = (state_q == RESP);
  assign ResId_DO        = id_q;
  assign Res_DO          = res_q;

endmodule

// File: tb/tb_mage_div_arbiter.sv
// Self-checking bench for mage_div_arbiter. The bench plays both the
// requesters and the divider; the divider answers with a value the bench
// chooses, so result pass-through and tagging can be checked exactly.

module tb_mage_div_arbiter;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int LW = 6;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    Req_SI;
  logic [N*W-1:0]  ReqOpA_DI;
  logic [N*W-1:0]  ReqOpB_DI;
  logic [N*2-1:0]  ReqOpCode_DI;
  logic [N-1:0]    Gnt_SO;
  logic [W-1:0]    DivOpA_DO;
  logic [W-1:0]    DivOpB_DO;
  logic [LW-1:0]   DivOpBShift_DO;
  logic            DivOpBIsZero_SO;
  logic            DivOpBSign_SO;
  logic [1:0]      DivOpCode_DO;
  logic            DivInVld_SO;
  logic            DivOutVld_SI;
  logic [W-1:0]    DivRes_DI;
  logic            DivOutRdy_SO;
  logic            ResVld_SO;
  logic [IW-1:0]   ResId_DO;
  logic [W-1:0]    Res_DO;
  logic            ResRdy_SI;

  int checks = 0;
  int errors = 0;
  int rrPtr  = 0;

  bit         reqValid[N];
  logic [W-1:0] reqA[N];
  logic [W-1:0] reqB[N];
  logic [1:0]   reqOp[N];

  typedef struct {
    int           idx;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] expOpB;
    int           expShift;
    bit           expZero;
    bit           expSign;
    logic [W-1:0] res;
  } vec_t;

  vec_t vecs[7];

  mage_div_arbiter #(.N_REQ(N), .C_WIDTH(W), .C_LOG_WIDTH(LW)) dut (
    .Clk_CI(clk), .Rst_RBI(rst_n),
    .Req_SI(Req_SI), .ReqOpA_DI(ReqOpA_DI), .ReqOpB_DI(ReqOpB_DI), .ReqOpCode_DI(ReqOpCode_DI),
    .Gnt_SO(Gnt_SO), .DivOpA_DO(DivOpA_DO), .DivOpB_DO(DivOpB_DO),
    .DivOpBShift_DO(DivOpBShift_DO), .DivOpBIsZero_SO(DivOpBIsZero_SO),
    .DivOpBSign_SO(DivOpBSign_SO), .DivOpCode_DO(DivOpCode_DO), .DivInVld_SO(DivInVld_SO),
    .DivOutVld_SI(DivOutVld_SI), .DivRes_DI(DivRes_DI), .DivOutRdy_SO(DivOutRdy_SO),
    .ResVld_SO(ResVld_SO), .ResId_DO(ResId_DO), .Res_DO(Res_DO), .ResRdy_SI(ResRdy_SI)
  );

  // Free-running 10ns clock.
  always #5 clk = ~clk;

  // Pack the per-requester bench arrays onto the DUT's flat input buses.
  always_comb begin
    Req_SI       = '0;
    ReqOpA_DI    = '0;
    ReqOpB_DI    = '0;
    ReqOpCode_DI = '0;
    for (int i = 0; i < N; i++) begin
      Req_SI[i]              = reqValid[i];
      ReqOpA_DI[i*W +: W]    = reqA[i];
      ReqOpB_DI[i*W +: W]    = reqB[i];
      ReqOpCode_DI[i*2 +: 2] = reqOp[i];
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_gnt"},     Gnt_SO, 0);
    checkOutput({tag, "_opa"},     DivOpA_DO, 0);
    checkOutput({tag, "_opb"},     DivOpB_DO, 0);
    checkOutput({tag, "_shift"},   DivOpBShift_DO, 0);
    checkOutput({tag, "_zero"},    DivOpBIsZero_SO, 0);
    checkOutput({tag, "_sign"},    DivOpBSign_SO, 0);
    checkOutput({tag, "_code"},    DivOpCode_DO, 0);
    checkOutput({tag, "_in_vld"},  DivInVld_SO, 0);
    checkOutput({tag, "_out_rdy"}, DivOutRdy_SO, 0);
    checkOutput({tag, "_res_vld"}, ResVld_SO, 0);
    checkOutput({tag, "_res_id"},  ResId_DO, 0);
    checkOutput({tag, "_res"},     Res_DO, 0);
  endtask

  task automatic applyStimulus(input int idx, input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    reqValid[idx] = 1'b1;
    reqOp[idx]    = op;
    reqA[idx]     = a;
    reqB[idx]     = b;
  endtask

  // Reference: grant is the first pending index at or after the pointer.
  function automatic int modelGrant();
    for (int k = 0; k < N; k++)
      if (reqValid[(rrPtr + k) % N]) return (rrPtr + k) % N;
    return -1;
  endfunction

  // Normalising shift = W minus the minimal width able to hold B
  // (unsigned width for unsigned ops, two's-complement width for signed).
  function automatic int modelShift(input logic [W-1:0] b, input logic [1:0] op);
    longint v;
    longint one;
    one = 1;
    if (b == '0) return 0;
    if (!op[0]) begin
      v = longint'({32'b0, b});
      for (int n = 1; n <= W; n++) if (v < (one << n)) return W - n;
    end else begin
      v = longint'($signed(b));
      for (int n = 1; n <= W; n++)
        if ((v >= -(one << (n-1))) && (v < (one << (n-1)))) return W - n;
    end
    return 0;
  endfunction

  // Divider answer used by the bench's divider model (RISC-V style results).
  function automatic logic [W-1:0] refDiv(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op);
    longint ua, ub, sa, sb, r;
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      2'd0:    r = (ub == 0) ? -1 : ua / ub;
      2'd1:    r = (sb == 0) ? -1 : sa / sb;
      2'd2:    r = (ub == 0) ? ua : ua % ub;
      default: r = (sb == 0) ? sa : sa % sb;
    endcase
    return r[W-1:0];
  endfunction

  // One complete operation, entered and left at a negedge in IDLE.
  task automatic runOp(input int expIdx, input logic [1:0] expOp, input logic [W-1:0] expA,
                       input logic [W-1:0] expOpB, input int expShift, input bit expZero,
                       input bit expSign, input logic [W-1:0] divRes, input int lat,
                       input int rdyWait, input bit drop);
    #1;
    checkOutput("gnt_idle", Gnt_SO, 64'(1) << expIdx);
    checkOutput("in_vld_idle", DivInVld_SO, 0);
    @(negedge clk);
    if (drop) reqValid[expIdx] = 1'b0;
    #1;
    checkOutput("gnt_issue", Gnt_SO, 0);
    checkOutput("in_vld_issue", DivInVld_SO, 1);
    checkOutput("op_a", DivOpA_DO, expA);
    checkOutput("op_b", DivOpB_DO, expOpB);
    checkOutput("op_shift", DivOpBShift_DO, 64'(expShift));
    checkOutput("op_zero", DivOpBIsZero_SO, expZero);
    checkOutput("op_sign", DivOpBSign_SO, expSign);
    checkOutput("op_code", DivOpCode_DO, expOp);
    @(negedge clk);
    for (int k = 0; k < lat; k++) begin
      #1;
      checkOutput("gnt_wait", Gnt_SO, 0);
      checkOutput("in_vld_wait", DivInVld_SO, 0);
      checkOutput("out_rdy_wait", DivOutRdy_SO, 0);
      checkOutput("res_vld_wait", ResVld_SO, 0);
      checkOutput("op_b_wait", DivOpB_DO, expOpB);
      checkOutput("op_a_wait", DivOpA_DO, expA);
      @(negedge clk);
    end
    DivOutVld_SI = 1'b1;
    DivRes_DI    = divRes;
    #1;
    checkOutput("out_rdy", DivOutRdy_SO, 1);
    checkOutput("res_vld_capture", ResVld_SO, 0);
    @(negedge clk);
    // Stray divider valid while holding the result must be ignored.
    DivRes_DI = ~divRes;
    for (int k = 0; k <= rdyWait; k++) begin
      #1;
      checkOutput("res_vld", ResVld_SO, 1);
      checkOutput("res", Res_DO, divRes);
      checkOutput("res_id", ResId_DO, 64'(expIdx));
      checkOutput("gnt_resp", Gnt_SO, 0);
      checkOutput("out_rdy_resp", DivOutRdy_SO, 0);
      if (k < rdyWait) @(negedge clk);
    end
    DivOutVld_SI = 1'b0;
    ResRdy_SI    = 1'b1;
    #1;
    checkOutput("gnt_resp_rdy", Gnt_SO, 0);
    @(negedge clk);
    ResRdy_SI = 1'b0;
    rrPtr = (expIdx + 1) % N;
  endtask

  task automatic doModelOp(input int idx, input int lat, input int rdyWait, input bit drop);
    int sh;
    sh = modelShift(reqB[idx], reqOp[idx]);
    runOp(idx, reqOp[idx], reqA[idx], reqB[idx] << sh, sh, reqB[idx] == '0,
          reqOp[idx][0] & reqB[idx][W-1], refDiv(reqA[idx], reqB[idx], reqOp[idx]),
          lat, rdyWait, drop);
  endtask

  task automatic newRandomReq(input int idx);
    logic [W-1:0] a, b;
    a = $urandom;
    case ($urandom_range(4, 0))
      0: b = '0;
      1: b = W'($urandom_range(20, 1));
      2: b = $urandom;
      3: b = -W'($urandom_range(20, 1));
      default: begin b = '1; a = 32'h8000_0000; end
    endcase
    applyStimulus(idx, 2'($urandom_range(3, 0)), a, b);
  endtask

  initial begin
    int g;
    bit any;
    vecs[0] = '{0, 2'd0, 32'd100, 32'd7,          32'hE000_0000, 29, 1'b0, 1'b0, 32'd14};
    vecs[1] = '{2, 2'd2, 32'd100, 32'd7,          32'hE000_0000, 29, 1'b0, 1'b0, 32'd2};
    vecs[2] = '{3, 2'd0, 32'd5,   32'd0,          32'h0000_0000, 0,  1'b1, 1'b0, 32'hFFFF_FFFF};
    vecs[3] = '{1, 2'd1, 32'd100, 32'hFFFF_FFF9,  32'h9000_0000, 28, 1'b0, 1'b1, 32'hFFFF_FFF2};
    vecs[4] = '{1, 2'd3, 32'hFFFF_FF9C, 32'd7,    32'h7000_0000, 28, 1'b0, 1'b0, 32'hFFFF_FFFE};
    vecs[5] = '{2, 2'd1, 32'd1,   32'd0,          32'h0000_0000, 0,  1'b1, 1'b0, 32'hFFFF_FFFF};
    vecs[6] = '{0, 2'd3, 32'd7,   32'h8000_0000,  32'h8000_0000, 0,  1'b0, 1'b1, 32'd7};

    for (int i = 0; i < N; i++) begin
      reqValid[i] = 1'b1;
      reqA[i] = 32'd100;
      reqB[i] = 32'd7;
      reqOp[i] = 2'd0;
    end
    rst_n = 1'b0;
    DivOutVld_SI = 1'b0;
    DivRes_DI = '0;
    ResRdy_SI = 1'b0;

    // Reset with every requester active: outputs must stay quiet.
    repeat (3) @(negedge clk);
    checkAllZero("in_reset");
    for (int i = 0; i < N; i++) reqValid[i] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkAllZero("after_reset");
    @(negedge clk);

    // Two requesters contending from reset: 0, 1, 0, 1; long consumer stall.
    rrPtr = 0;
    applyStimulus(0, 2'd0, 32'd100, 32'd7);
    applyStimulus(1, 2'd2, 32'd100, 32'd7);
    doModelOp(0, 2, 0, 1'b0);
    doModelOp(1, 0, 10, 1'b0);
    doModelOp(0, 3, 1, 1'b1);
    doModelOp(1, 1, 0, 1'b1);

    // Directed table: one requester at a time.
    for (int v = 0; v < 7; v++) begin
      applyStimulus(vecs[v].idx, vecs[v].op, vecs[v].a, vecs[v].b);
      runOp(vecs[v].idx, vecs[v].op, vecs[v].a, vecs[v].expOpB, vecs[v].expShift,
            vecs[v].expZero, vecs[v].expSign, vecs[v].res, v % 3, v % 2, 1'b1);
    end

    // Randomised traffic against the reference arbiter and divider model.
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < N; i++)
        if (!reqValid[i] && ($urandom_range(1, 0) == 1)) newRandomReq(i);
      any = 1'b0;
      for (int i = 0; i < N; i++) any |= reqValid[i];
      if (!any) newRandomReq(int'($urandom_range(N-1, 0)));
      g = modelGrant();
      doModelOp(g, int'($urandom_range(5, 0)), int'($urandom_range(3, 0)), 1'b1);
    end
    for (int i = 0; i < N; i++) reqValid[i] = 1'b0;

    // Reset while waiting on the divider, then pointer must restart at 0.
    @(negedge clk);
    applyStimulus(0, 2'd0, 32'd50, 32'd3);
    #1;
    checkOutput("abort_gnt", Gnt_SO, 64'd1);
    @(negedge clk);
    reqValid[0] = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkAllZero("abort_reset");
    applyStimulus(0, 2'd2, 32'd50, 32'd3);
    applyStimulus(1, 2'd0, 32'd60, 32'd4);
    #1;
    checkOutput("abort_gnt_in_reset", Gnt_SO, 0);
    @(negedge clk);
    rst_n = 1'b1;
    rrPtr = 0;
    doModelOp(0, 1, 0, 1'b1);
    doModelOp(1, 0, 0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
